// File: rtl/sid_dac_sched.sv
// rtl/sid_dac_sched.sv - round-robin scheduler sharing one serial bit-weighted DAC engine
module sid_dac_sched #(
   parameter int N_REQ     = 4,
   parameter int SCALEBITS = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [2*N_REQ-1:0]         req_kind,
   input  logic [12*N_REQ-1:0]        req_data,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       rom_en,
   output logic [5:0]                 rom_addr,
   input  logic [15:0]                rom_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(N_REQ)-1:0]   out_id,
   output logic [1:0]                 out_kind,
   output logic [11:0]                out_data
);

   localparam int IDW = $clog2(N_REQ);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

   // Number of DAC bits for a (normalised) kind: waveform 12, cutoff 11, envelope 8.
   function automatic logic [3:0] bits_of(input logic [1:0] k);
      case (k)
         2'd1:    bits_of = 4'd11;
         2'd2:    bits_of = 4'd8;
         default: bits_of = 4'd12;
      endcase
   endfunction

   function automatic logic [11:0] mask_of(input logic [1:0] k);
      mask_of = 12'hFFF >> (4'd12 - bits_of(k));
   endfunction

   state_t           state_q, state_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [1:0]       kind_q, kind_d;
   logic [11:0]      data_q, data_d;
   logic [15:0]      acc_q, acc_d;
   logic [3:0]       bit_q, bit_d;
   logic             rd_pend_q, rd_pend_d;
   logic [3:0]       rd_bit_q, rd_bit_d;

   logic             gnt_found;
   logic [IDW-1:0]   gnt_idx;
   logic [1:0]       gnt_kind;
   int               cand;

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = (int'(last_q) + k) % N_REQ;
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'(cand);
         end
      end
      gnt_kind = req_kind[int'(gnt_idx)*2 +: 2];
      if (gnt_kind == 2'd3) gnt_kind = 2'd0;
   end

   // Next-state: grant, issue one ROM read per bit, fold each read in on the following cycle.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      id_d      = id_q;
      kind_d    = kind_q;
      data_d    = data_q;
      acc_d     = acc_q;
      bit_d     = bit_q;
      rd_pend_d = (state_q == S_ISSUE);
      rd_bit_d  = bit_q;
      if (rd_pend_q && data_q[rd_bit_q]) acc_d = acc_q + rom_data;
      case (state_q)
         S_IDLE: begin
            if (gnt_found) begin
               last_d  = gnt_idx;
               id_d    = gnt_idx;
               kind_d  = gnt_kind;
               data_d  = req_data[int'(gnt_idx)*12 +: 12] & mask_of(gnt_kind);
               acc_d   = 16'(1) << (SCALEBITS - 1);
               bit_d   = 4'd0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            bit_d = bit_q + 4'd1;
            if (bit_q == bits_of(kind_q) - 4'd1) state_d = S_DRAIN;
         end
         S_DRAIN: state_d = S_OUT;
         default: if (out_ready) state_d = S_IDLE;
      endcase
   end

   // State registers; reset abandons any conversion in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         last_q    <= IDW'(N_REQ - 1);
         id_q      <= '0;
         kind_q    <= 2'd0;
         data_q    <= 12'd0;
         acc_q     <= 16'd0;
         bit_q     <= 4'd0;
         rd_pend_q <= 1'b0;
         rd_bit_q  <= 4'd0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         id_q      <= id_d;
         kind_q    <= kind_d;
         data_q    <= data_d;
         acc_q     <= acc_d;
         bit_q     <= bit_d;
         rd_pend_q <= rd_pend_d;
         rd_bit_q  <= rd_bit_d;
      end
   end

   // Outputs decode the state register; all forced quiet while reset is held.
   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && gnt_found && !rst) req_ready[gnt_idx] = 1'b1;
      rom_en    = (state_q == S_ISSUE) && !rst;
      rom_addr  = rom_en ? {kind_q, bit_q} : 6'd0;
      out_valid = (state_q == S_OUT) && !rst;
      out_id    = out_valid ? id_q : '0;
      out_kind  = out_valid ? kind_q : 2'd0;
      out_data  = out_valid ? 12'((acc_q >> SCALEBITS) & {4'h0, mask_of(kind_q)}) : 12'd0;
   end

endmodule

// File: tb/tb_sid_dac_sched.sv
// tb/tb_sid_dac_sched.sv - directed self-checking bench for sid_dac_sched
module tb_sid_dac_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [7:0]  req_kind;
   logic [47:0] req_data;
   logic [3:0]  req_ready;
   logic        rom_en;
   logic [5:0]  rom_addr;
   logic [15:0] rom_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_id;
   logic [1:0]  out_kind;
   logic [11:0] out_data;

   logic [15:0] rom [64];
   int checks = 0;
   int fails  = 0;
   int cyc_n  = 0;

   sid_dac_sched #(.N_REQ(4), .SCALEBITS(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_kind(req_kind), .req_data(req_data), .req_ready(req_ready),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_id(out_id), .out_kind(out_kind), .out_data(out_data)
   );

   always #5 clk = ~clk;

   // ROM model: data valid one cycle after the strobe
   always @(posedge clk) rom_data <= rom_en ? rom[rom_addr] : 16'h0000;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc_n);
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 4'b0000; out_ready = 1'b1;
      cyc(); cyc(); #1;
      checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rst_hold_ready got %b want 0000", req_ready); end
      checks++; if (rom_en !== 1'b0) begin fails++; $display("FAIL rst_hold_rom_en got %b want 0", rom_en); end
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_hold_out_valid got %b want 0", out_valid); end
      rst = 1'b0;
      cyc(); #1;
      checks++; if (rom_addr !== 6'd0) begin fails++; $display("FAIL rst_after_rom_addr got %h want 00", rom_addr); end
      checks++; if ({out_valid, out_id, out_kind, out_data} !== 17'd0) begin fails++;
         $display("FAIL rst_after_outputs got v=%b id=%0d k=%0d d=%h want all 0", out_valid, out_id, out_kind, out_data); end
   endtask

   task automatic test_conversion(input string lbl, input int id, input logic [1:0] kind,
                                  input logic [11:0] data, input logic [11:0] exp_data,
                                  input logic [1:0] exp_kind, input int exp_lat, input int exp_roms);
      int n, lat, roms;
      req_kind = '0; req_data = '0;
      req_kind[id*2 +: 2] = kind;
      req_data[id*12 +: 12] = data;
      req_valid = 4'(1 << id);
      #1;
      n = 0;
      while (req_ready[id] !== 1'b1 && n < 20) begin cyc(); #1; n++; end
      checks++; if (req_ready !== 4'(1 << id)) begin fails++; $display("FAIL %s grant got %b want %b", lbl, req_ready, 4'(1 << id)); end
      checks++; if (rom_en !== 1'b0) begin fails++; $display("FAIL %s idle_rom_en got %b want 0", lbl, rom_en); end
      cyc(); req_valid = 4'b0000; #1;
      lat = 1; roms = 0;
      checks++; if (rom_addr !== {exp_kind, 4'd0}) begin fails++; $display("FAIL %s first_addr got %h want %h", lbl, rom_addr, {exp_kind, 4'd0}); end
      while (out_valid !== 1'b1 && lat < 40) begin
         if (rom_en === 1'b1) roms++;
         cyc(); #1; lat++;
      end
      checks++; if (lat != exp_lat) begin fails++; $display("FAIL %s latency got %0d want %0d", lbl, lat, exp_lat); end
      checks++; if (out_data !== exp_data) begin fails++; $display("FAIL %s data got %h want %h", lbl, out_data, exp_data); end
      checks++; if (out_id !== 2'(id)) begin fails++; $display("FAIL %s id got %0d want %0d", lbl, out_id, id); end
      checks++; if (out_kind !== exp_kind) begin fails++; $display("FAIL %s kind got %0d want %0d", lbl, out_kind, exp_kind); end
      checks++; if (roms != exp_roms) begin fails++; $display("FAIL %s rom_reads got %0d want %0d", lbl, roms, exp_roms); end
      cyc(); #1;
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL %s out_valid_after_hs got %b want 0", lbl, out_valid); end
   endtask

   task automatic test_rounding();
      rom[0] = 16'd7;
      test_conversion("round7", 0, 2'd0, 12'h001, 12'h000, 2'd0, 14, 12);
      rom[0] = 16'd8;
      test_conversion("round8", 0, 2'd0, 12'h001, 12'h001, 2'd0, 14, 12);
      rom[0] = 16'd16;
   endtask

   task automatic test_round_robin();
      int g [4];
      int gc [4];
      int ng, n;
      rst = 1'b1; cyc(); rst = 1'b0; cyc();
      req_kind = '0; req_data = '0; out_ready = 1'b1;
      req_valid = 4'b0101;
      ng = 0;
      for (int c = 0; c < 80 && ng < 4; c++) begin
         #1;
         if (req_ready !== 4'b0000) begin
            checks++; if (!$onehot(req_ready) || (req_ready & 4'b1010) !== 4'b0000) begin fails++;
               $display("FAIL rr_ready_shape got %b want one of 0001/0100", req_ready); end
            g[ng]  = req_ready[2] ? 2 : 0;
            gc[ng] = cyc_n;
            ng++;
         end
         cyc();
      end
      req_valid = 4'b0000;
      checks++; if (ng != 4) begin fails++; $display("FAIL rr_grant_count got %0d want 4", ng); end
      if (ng == 4) begin
         checks++; if (g[0] != 0 || g[1] != 2 || g[2] != 0 || g[3] != 2) begin fails++;
            $display("FAIL rr_order got %0d,%0d,%0d,%0d want 0,2,0,2", g[0], g[1], g[2], g[3]); end
         checks++; if (gc[1] - gc[0] != 15 || gc[3] - gc[2] != 15) begin fails++;
            $display("FAIL rr_spacing got %0d,%0d want 15,15", gc[1] - gc[0], gc[3] - gc[2]); end
      end
      n = 0;
      while (out_valid !== 1'b1 && n < 30) begin cyc(); #1; n++; end
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rr_drain out_valid got %b want 1", out_valid); end
      cyc();
   endtask

   task automatic test_stall();
      int n, bad;
      req_kind = '0; req_data = '0;
      req_kind[7:6] = 2'd2;
      req_data[47:36] = 12'h05A;
      out_ready = 1'b0;
      req_valid = 4'b1000;
      #1;
      n = 0;
      while (req_ready[3] !== 1'b1 && n < 20) begin cyc(); #1; n++; end
      checks++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL stall_grant got %b want 1000", req_ready); end
      cyc(); req_valid = 4'b0001; #1;
      n = 0; bad = 0;
      while (out_valid !== 1'b1 && n < 30) begin
         if (req_ready !== 4'b0000) bad++;
         cyc(); #1; n++;
      end
      checks++; if (bad != 0 || n != 9) begin fails++; $display("FAIL stall_busy got ready_cycles=%0d wait=%0d want 0 and 9", bad, n); end
      for (int s = 0; s < 5; s++) begin
         checks++; if (out_valid !== 1'b1 || out_data !== 12'h05A || out_id !== 2'd3 || out_kind !== 2'd2) begin fails++;
            $display("FAIL stall_hold[%0d] got v=%b d=%h id=%0d k=%0d want 1,05a,3,2", s, out_valid, out_data, out_id, out_kind); end
         checks++; if (rom_en !== 1'b0 || req_ready !== 4'b0000) begin fails++;
            $display("FAIL stall_quiet[%0d] got rom_en=%b ready=%b want 0,0000", s, rom_en, req_ready); end
         cyc(); #1;
      end
      out_ready = 1'b1; #1;
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stall_release out_valid got %b want 1", out_valid); end
      cyc(); #1;
      checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL stall_next_grant got %b want 0001", req_ready); end
      cyc(); req_valid = 4'b0000; #1;
      n = 0;
      while (out_valid !== 1'b1 && n < 30) begin cyc(); #1; n++; end
      cyc();
   endtask

   task automatic test_reset_abort();
      int n, bad;
      req_kind = '0; req_data = '0;
      req_data[35:24] = 12'hFFF;
      out_ready = 1'b1;
      req_valid = 4'b0100;
      #1;
      n = 0;
      while (req_ready[2] !== 1'b1 && n < 20) begin cyc(); #1; n++; end
      checks++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL abort_grant got %b want 0100", req_ready); end
      cyc(); req_valid = 4'b0000;
      cyc(); cyc(); cyc(); #1;
      checks++; if (rom_en !== 1'b1) begin fails++; $display("FAIL abort_in_issue rom_en got %b want 1", rom_en); end
      rst = 1'b1; #1;
      checks++; if (rom_en !== 1'b0 || rom_addr !== 6'd0 || out_valid !== 1'b0) begin fails++;
         $display("FAIL abort_during_rst got rom_en=%b addr=%h v=%b want 0,00,0", rom_en, rom_addr, out_valid); end
      cyc(); rst = 1'b0; #1;
      checks++; if ({rom_en, rom_addr, out_valid, out_id, out_kind, out_data, req_ready} !== 28'd0) begin fails++;
         $display("FAIL abort_after_rst got rom_en=%b addr=%h v=%b id=%0d k=%0d d=%h rdy=%b want all 0",
                  rom_en, rom_addr, out_valid, out_id, out_kind, out_data, req_ready); end
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (out_valid !== 1'b0 || rom_en !== 1'b0) bad++;
         cyc(); #1;
      end
      checks++; if (bad != 0) begin fails++; $display("FAIL abort_no_result got active_cycles=%0d want 0", bad); end
      req_valid = 4'b1111; #1;
      checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL abort_first_grant got %b want 0001", req_ready); end
      cyc(); req_valid = 4'b0000; #1;
      n = 0;
      while (out_valid !== 1'b1 && n < 30) begin cyc(); #1; n++; end
      cyc();
   endtask

   initial begin
      for (int k = 0; k < 4; k++)
         for (int b = 0; b < 16; b++)
            rom[k*16 + b] = (b < 12) ? 16'(16 << b) : 16'h0000;
      rst = 1'b1; req_valid = '0; req_kind = '0; req_data = '0; out_ready = 1'b1;
      test_reset();
      test_conversion("waveform", 1, 2'd0, 12'hABC, 12'hABC, 2'd0, 14, 12);
      test_conversion("cutoff",   2, 2'd1, 12'hFFF, 12'h7FF, 2'd1, 13, 11);
      test_conversion("envelope", 0, 2'd2, 12'hFFF, 12'h0FF, 2'd2, 10, 8);
      test_conversion("kind3",    3, 2'd3, 12'h123, 12'h123, 2'd0, 14, 12);
      test_rounding();
      test_round_robin();
      test_stall();
      test_reset_abort();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/sid_dac_sched.md
SID_DAC_SCHED -- requirements
Module: sid_dac_sched

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing the serial DAC engine (range 2..8).
REQ-002 Parameter: SCALEBITS, default 4, fractional bits in each ROM bit value.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  N_REQ  per-requester conversion request.
REQ-006 req_kind  input  2*N_REQ  per-requester DAC kind: 0 waveform (12 bits), 1 cutoff (11 bits), 2 envelope (8 bits), 3 treated as 0.
REQ-007 req_data  input  12*N_REQ  per-requester DAC input code, right-aligned; bits at or above the kind's BITS are ignored.
REQ-008 req_ready  output  N_REQ  one-hot accept pulse; request i is consumed in the cycle req_valid[i] and req_ready[i] are both high.
REQ-009 rom_en  output  1  bit-value ROM read strobe.
REQ-010 rom_addr  output  6  ROM address {kind[1:0], bit[3:0]}.
REQ-011 rom_data  input  16  ROM bit value, scaled by 2^SCALEBITS, valid exactly 1 cycle after rom_en.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_id  output  clog2(N_REQ)  index of requester owning the result.
REQ-015 out_kind  output  2  kind of the result (3 reported as 0).
REQ-016 out_data  output  12  DAC output, right-aligned; bits at or above BITS are 0.

Function
REQ-017 FSM states: IDLE, ISSUE, DRAIN, OUT; exactly one active.
REQ-018 IDLE: if any req_valid high, grant one requester by round-robin, assert its req_ready for that cycle only, latch id/kind/data, load accumulator with 2^(SCALEBITS-1), clear bit counter, go to ISSUE; otherwise stay.
REQ-019 Round-robin: search starts at (last_grant+1) mod N_REQ; last_grant updates on each grant; reset value N_REQ-1, so requester 0 has first priority.
REQ-020 req_ready is 0 in every state other than IDLE; at most one bit of req_ready is set in any cycle.
REQ-021 ISSUE: for bit counter b = 0..BITS-1, one per cycle, drive rom_en=1 and rom_addr={kind,b}; after b=BITS-1 go to DRAIN.
REQ-022 Accumulate: in each cycle following a rom_en, if latched data bit b of that read is 1, add rom_data to the 16-bit accumulator; otherwise leave it unchanged.
REQ-023 DRAIN: performs the final accumulate; rom_en=0; next state OUT.
REQ-024 OUT: out_valid=1; out_data = accumulator[BITS+SCALEBITS-1:SCALEBITS], zero-extended; out_id and out_kind reflect the latched request; all stay stable until out_ready=1.
REQ-025 Output handshake completes when out_valid and out_ready are high in the same cycle; the FSM enters IDLE on the next cycle, and a new grant is possible in that IDLE cycle.
REQ-026 Latency: a request accepted in cycle T has out_valid first high in cycle T+BITS+2 (waveform 14, cutoff 13, envelope 10).
REQ-027 Accumulator is 16 bits with no saturation; an all-ones code with an ideal table cannot overflow.
REQ-028 rom_en=0 and rom_addr=0 outside ISSUE.
REQ-029 req_valid dropping for a non-granted requester has no effect; a request withdrawn while not granted is never converted.

Reset
REQ-030 While rst=1 and on the cycle after: state IDLE, req_ready=0, rom_en=0, rom_addr=0, out_valid=0, out_id=0, out_kind=0, out_data=0, accumulator=0, last_grant=N_REQ-1.
REQ-031 Reset asserted in any state (ISSUE, DRAIN, OUT) aborts the conversion and discards its result; no out_valid is issued for it.

Verification
REQ-032 Ideal table (value = 2^b*16), requester 1 waveform 0xABC, out_ready=1 -> out_valid 14 cycles after accept, out_id=1, out_kind=0, out_data=0xABC.
REQ-033 Ideal table, envelope 0xFFF -> out_data=0x0FF, 8 rom_en pulses, latency 10.
REQ-034 Rounding: waveform table bit0 value 7, code 0x001 -> out_data=0x000; bit0 value 8 -> out_data=0x001.
REQ-035 Requesters 0 and 2 held valid continuously -> grants alternate 0,2,0,2; requesters 1 and 3 never granted; no req_ready while busy.
REQ-036 out_ready held low 5 cycles in OUT -> out_valid and out_data stable, rom_en=0, no req_ready; grant occurs the cycle after out_ready rises.
REQ-037 rst pulsed mid-ISSUE -> next cycle all outputs at reset values; requester 0 is granted first afterwards.
